// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V main control FSM:
// state encoding, opcodes and datapath select encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } statetype_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // True for every opcode this controller knows how to sequence.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE,
            OP_ITYPE, OP_BRANCH, OP_JAL: ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/controller_fsm_next_state_logic.sv
// Combinational next-state function of the main control FSM.
// mem_ready arrives already resolved against the handshake parameter.
module next_state_logic
    import riscv_ctrl_pkg::*;
(
    input  statetype_t  state,
    input  logic [6:0]  op,
    input  logic        mem_ready,
    output statetype_t  next_state
);

    // Next-state selection; unknown encodings recover to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
                else           next_state = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECUTER;
                    OP_ITYPE:          next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) next_state = S_MEMREAD;
                else               next_state = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) next_state = S_MEMWB;
                else           next_state = S_MEMREAD;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) next_state = S_FETCH;
                else           next_state = S_MEMWRITE;
            end
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/controller_fsm.sv
// Multicycle RISC-V main controller: state register plus Moore output
// decode, with FETCH enables gated by the memory-ready handshake.
module controller_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       IllegalInstr
);

    statetype_t state_r;
    statetype_t next_state_s;
    logic       ready_s;
    logic       pcupdate_s;
    logic       branch_s;

    assign ready_s = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    next_state_logic u_next_state (
        .state      (state_r),
        .op         (op),
        .mem_ready  (ready_s),
        .next_state (next_state_s)
    );

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_FETCH;
        else       state_r <= next_state_s;
    end

    // Output decode from state, then reset forces all write enables low.
    always_comb begin
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = RESULT_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_WD;
        ALUOp        = ALUOP_ADD;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        pcupdate_s   = 1'b0;
        branch_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                ResultSrc  = RESULT_ALURESULT;
                ALUSrcB    = SRCB_FOUR;
                IRWrite    = ready_s;
                pcupdate_s = ready_s;
            end
            S_DECODE: begin
                // Branch target (OldPC + imm) is parked in ALUOut here.
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_IMM;
                IllegalInstr = ~op_supported(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RESULT_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REGA;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_REGA;
                ALUOp    = ALUOP_SUB;
                branch_s = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcupdate_s = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase

        if (reset) begin
            AdrSrc       = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            ResultSrc    = RESULT_ALURESULT;
            ALUSrcA      = SRCA_PC;
            ALUSrcB      = SRCB_FOUR;
            ALUOp        = ALUOP_ADD;
            RegWrite     = 1'b0;
            IllegalInstr = 1'b0;
            pcupdate_s   = 1'b0;
            branch_s     = 1'b0;
        end else begin
            IllegalInstr = IllegalInstr;
        end

        PCWrite = pcupdate_s | (branch_s & Zero);
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: each step drives inputs, queues the
// expected output vector from a table model, and compares it mid-cycle.
module tb_controller_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                   XR = 6, XI = 7, AWB = 8, BQ = 9, JL = 10;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JA = 7'b1101111,
                           BAD = 7'b1111111;

    controller_fsm #(.MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    // Output vector layout:
    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, IllegalInstr}
    function automatic logic [13:0] model(input int st, input logic mr,
                                          input logic z, input logic ill);
        case (st)
            F:   return {mr,   1'b0, 1'b0, mr,   2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
            D:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, ill};
            MA:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
            MR:  return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            MWB: return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
            MW:  return {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            XR:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
            XI:  return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
            AWB: return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
            BQ:  return {z,    1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
            JL:  return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
            default: return 14'h0000;
        endcase
    endfunction

    function automatic logic [13:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, RegWrite, IllegalInstr};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle in state st: drive, queue expectation, sample at negedge.
    task automatic step(input string tag, input int st, input logic [6:0] o,
                        input logic z, input logic mr);
        logic [13:0] e;
        op = o;
        Zero = z;
        MemReady = mr;
        exp_q.push_back(model(st, mr, z, (st == D) && (o == BAD)));
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, observed(), e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: FETCH selects visible, every enable low.
        #3;
        chk("reset_outputs", observed(), {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        // R-type, no waits: 4 cycles.
        step("r_fetch", F,   RT, 1'b0, 1'b1);
        step("r_decode", D,  RT, 1'b0, 1'b1);
        step("r_exec", XR,   RT, 1'b0, 1'b1);
        step("r_wb", AWB,    RT, 1'b0, 1'b1);

        // lw with 2 fetch waits and 3 memread waits: 10 cycles.
        step("lw_fetch_w0", F, LW, 1'b0, 1'b0);
        step("lw_fetch_w1", F, LW, 1'b0, 1'b0);
        step("lw_fetch", F,    LW, 1'b0, 1'b1);
        step("lw_decode", D,   LW, 1'b0, 1'b1);
        step("lw_memadr", MA,  LW, 1'b0, 1'b1);
        step("lw_rd_w0", MR,   LW, 1'b0, 1'b0);
        step("lw_rd_w1", MR,   LW, 1'b0, 1'b0);
        step("lw_rd_w2", MR,   LW, 1'b0, 1'b0);
        step("lw_rd", MR,      LW, 1'b0, 1'b1);
        step("lw_wb", MWB,     LW, 1'b0, 1'b1);

        // sw with 2 memwrite waits: MemWrite held 3 cycles.
        step("sw_fetch", F,   SW, 1'b0, 1'b1);
        step("sw_decode", D,  SW, 1'b0, 1'b1);
        step("sw_memadr", MA, SW, 1'b0, 1'b1);
        step("sw_wr_w0", MW,  SW, 1'b0, 1'b0);
        step("sw_wr_w1", MW,  SW, 1'b0, 1'b0);
        step("sw_wr", MW,     SW, 1'b0, 1'b1);

        // beq taken then not taken: 3 cycles each.
        step("beq1_fetch", F,  BR, 1'b1, 1'b1);
        step("beq1_decode", D, BR, 1'b1, 1'b1);
        step("beq1_taken", BQ, BR, 1'b1, 1'b1);
        step("beq2_fetch", F,  BR, 1'b0, 1'b1);
        step("beq2_decode", D, BR, 1'b0, 1'b1);
        step("beq2_not", BQ,   BR, 1'b0, 1'b1);

        // I-type and jal: 4 cycles each.
        step("i_fetch", F,   IT, 1'b0, 1'b1);
        step("i_decode", D,  IT, 1'b0, 1'b1);
        step("i_exec", XI,   IT, 1'b0, 1'b1);
        step("i_wb", AWB,    IT, 1'b0, 1'b1);
        step("jal_fetch", F, JA, 1'b0, 1'b1);
        step("jal_decode", D, JA, 1'b0, 1'b1);
        step("jal_exec", JL, JA, 1'b0, 1'b1);
        step("jal_wb", AWB,  JA, 1'b0, 1'b1);

        // Illegal opcode: single IllegalInstr pulse, straight back to FETCH.
        step("ill_fetch", F,  BAD, 1'b0, 1'b1);
        step("ill_decode", D, BAD, 1'b0, 1'b1);
        step("ill_after", F,  RT,  1'b0, 1'b1);
        step("ill_nop_dec", D, RT, 1'b0, 1'b1);
        step("ill_nop_ex", XR, RT, 1'b0, 1'b1);
        step("ill_nop_wb", AWB, RT, 1'b0, 1'b1);

        // Reset asserted in MEMWRITE while MemReady is low.
        step("rst_fetch", F,   SW, 1'b0, 1'b1);
        step("rst_decode", D,  SW, 1'b0, 1'b1);
        step("rst_memadr", MA, SW, 1'b0, 1'b1);
        step("rst_wr_w0", MW,  SW, 1'b0, 1'b0);
        chk("rst_pre", observed(), model(MW, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        #1;
        chk("rst_async", observed(), {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        chk("rst_fetch_mr0", observed(), model(F, 1'b0, 1'b0, 1'b0));
        MemReady = 1'b1;
        #1;
        chk("rst_fetch_mr1", observed(), model(F, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        step("rst_resume_dec", D, SW, 1'b0, 1'b1);
        step("rst_resume_ma", MA, SW, 1'b0, 1'b1);
        step("rst_resume_wr", MW, SW, 1'b0, 1'b1);
        step("rst_resume_f", F,   SW, 1'b0, 1'b1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_fsm.md
Name: controller_fsm

Overview:
- Multicycle RISC-V main control FSM; sits directly upstream of the ALU decoder and drives its 2-bit ALUOp.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the datapath mux selects and write enables.
- Supports a memory-ready handshake so instruction and data memory may take multiple cycles.

Parameters:
- MEM_HANDSHAKE, 1, when 1 the FETCH, MEMREAD and MEMWRITE states wait for MemReady; when 0, MemReady is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; state returns to FETCH
- op  input  7  opcode field of the instruction register (instr[6:0])
- Zero  input  1  ALU zero flag, used in BEQ
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  PC register enable, equal to PCUpdate | (Branch & Zero)
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A
- ALUSrcB  output  2  ALU B select: 00 = register WriteData, 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded
- RegWrite  output  1  register file write enable
- IllegalInstr  output  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high, and forces state = FETCH.
- Write enables during reset: while reset is high, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced to 0.
- Mux selects during reset: selects show the FETCH decode (AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10).
- Output style: Moore outputs decoded from the state register. Exceptions: IRWrite and PCUpdate are gated by MemReady in FETCH; PCWrite depends on Zero in BEQ.
- Latencies with zero memory wait:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - beq: 3 cycles
  - jal: 4 cycles
- Each wait cycle with MemReady = 0 adds one cycle.
- Unlisted outputs are 0 in each state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=MemReady, PCUpdate=MemReady. Next state is DECODE if MemReady, else FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computed into ALUOut). Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH, with IllegalInstr = 1 for this cycle (executed as a NOP; PC already advanced).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB if MemReady, else MEMREAD.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemReady. Next state is FETCH if MemReady, else MEMWRITE.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, so PCWrite = Zero. Next state is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB (rd <= OldPC + 4).
- op sampling: op is only sampled outside FETCH. IR changes only in FETCH, so op is stable from DECODE through the end of the instruction.
- Reset mid-operation: any state goes to FETCH immediately and asynchronously. A pending MemWrite or RegWrite is dropped that same cycle.
- Simultaneous events: MemReady arriving in the first cycle of MEMREAD or MEMWRITE advances with no wait cycles.
- Unknown state encoding: next state is FETCH and all enables are 0.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum statetype_t (11 states)
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - encoding constants for ALUOp, ResultSrc, ALUSrcA and ALUSrcB.
- The controller_fsm module contains the state register, next-state logic and output decode.
- Sub-module next_state_logic (combinational: state, op, MemReady -> next state) is natural and keeps the output decode flat.

Test Plan:
- R-type add, MemReady tied to 1: op=0110011.
  - Expect FETCH -> DECODE -> EXECUTER -> ALUWB -> FETCH.
  - ALUOp=10 in EXECUTER.
  - RegWrite=1 only in cycle 4.
- lw with memory waits: MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD.
  - IRWrite and PCWrite pulse exactly once.
  - Total 10 cycles.
  - RegWrite=1 with ResultSrc=01 exactly once.
- sw with MemReady low for 2 cycles in MEMWRITE: MemWrite=1 for 3 consecutive cycles with AdrSrc=1, then FETCH.
- beq twice: first pass Zero=1 -> PCWrite=1 in BEQ with ALUOp=01; second pass Zero=0 -> PCWrite=0. Both take 3 cycles.
- Illegal opcode op=1111111: IllegalInstr=1 for exactly one cycle in DECODE, next state FETCH, no RegWrite or MemWrite.
- Reset asserted in MEMWRITE with MemReady=0: MemWrite drops in the same cycle without a clock edge; after deassert the FSM is in FETCH with IRWrite=MemReady.
